// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding and default width.
package serial_arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/fs_nand.sv
// One-bit full subtractor (d = x - y - bin) built from nine 2-input NAND gates.
module fs_nand (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic n1, n2, n3, hd;
    logic m1, m2, m3;

    // Stage 1: x - y; n3 is the active-low stage borrow (~x & y).
    nand g1 (n1, x, y);
    nand g2 (n2, x, n1);
    nand g3 (n3, y, n1);
    nand g4 (hd, n2, n3);

    // Stage 2: hd - bin; m3 is the active-low stage borrow (~hd & bin).
    nand g5 (m1, hd, bin);
    nand g6 (m2, hd, m1);
    nand g7 (m3, bin, m1);
    nand g8 (d, m2, m3);

    // OR of the two stage borrows from their inverted forms.
    nand g9 (bout, n3, m3);

endmodule

// File: rtl/serial_sub_nand.sv
// Bit-serial subtractor diff = a - b, LSB first, using a single NAND full-subtractor cell.
// Optional macro SERIAL_SUB_SIGNED_OVF_EN adds the two's-complement overflow output ovf.
module serial_sub_nand
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-2:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             accept, last;
    logic             bit_d, bit_bo;

    fs_nand u_fs (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (borrow_q),
        .d    (bit_d),
        .bout (bit_bo)
    );

    assign accept = (state_q != RUN) && start;
    assign last   = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Operand capture, one bit per RUN cycle, result commit on the last bit.
    // dsr holds the low WIDTH-1 result bits; the final bit joins them at commit.
    always_comb begin
        sa_d     = sa_q;
        sb_d     = sb_q;
        dsr_d    = dsr_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        if (accept) begin
            sa_d     = a;
            sb_d     = b;
            borrow_d = 1'b0;
            cnt_d    = '0;
        end else if (state_q == RUN) begin
            sa_d     = sa_q >> 1;
            sb_d     = sb_q >> 1;
            dsr_d    = (WIDTH-1)'({bit_d, dsr_q} >> 1);
            borrow_d = bit_bo;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last) begin
                diff_d = {bit_d, dsr_q};
                bout_d = bit_bo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa_q     <= '0;
            sb_q     <= '0;
            dsr_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dsr_q    <= dsr_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = bout_q;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: borrow into the MSB differs from borrow out of it.
    always_comb begin
        ovf_d = ovf_q;
        if (last) begin
            ovf_d = borrow_q ^ bit_bo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_nand.sv
// Self-checking bench for serial_sub_nand: directed table, corner sequences and random operands.
module tb_serial_sub_nand;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_i, b_i;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    serial_sub_nand #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a_i),
        .b          (b_i),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: plain integer subtraction, unsigned compare and signed range test.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] md, output logic mb, output logic mo);
        int sd;
        md = W'(av - bv);
        mb = (av < bv);
        sd = int'($signed(av)) - int'($signed(bv));
        mo = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    endtask

    // Called at a negedge with the DUT in IDLE or DONE; leaves us at the negedge of the DONE cycle
    // (chain=1) or one cycle later in IDLE (chain=0).
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit hold, input bit mid_change, input bit chain,
                         output logic [W-1:0] gd, output logic gb, output logic go);
        logic [W-1:0] prev, md;
        logic         mb, mo;
        bit           stable;
        int           e;
        a_i   = av;
        b_i   = bv;
        start = 1'b1;
        prev  = diff;
        @(posedge clk); @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'(1));
        if (!hold) start = 1'b0;
        stable = 1'b1;
        e = 0;
        while (!done && e < 4 * W) begin
            if (mid_change && e == 2) begin
                a_i = 8'hFF;
                b_i = 8'h00;
            end
            if (e == W - 1) start = 1'b0;
            @(posedge clk); @(negedge clk);
            e++;
            if (!done && diff !== prev) stable = 1'b0;
        end
        chk("latency", 32'(e), 32'(W));
        chk("diff_held_during_run", 32'(stable), 32'(1));
        chk("busy_in_done", 32'(busy), 32'(0));
        model(av, bv, md, mb, mo);
        chk("diff_vs_model", 32'(diff), 32'(md));
        chk("borrow_vs_model", 32'(borrow_out), 32'(mb));
        gd = diff;
        gb = borrow_out;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk("ovf_vs_model", 32'(ovf), 32'(mo));
        go = ovf;
`else
        go = mo;
`endif
        if (!chain) begin
            start = 1'b0;
            @(posedge clk); @(negedge clk);
            chk("done_single_pulse", 32'(done), 32'(0));
            chk("idle_after_done", 32'(busy), 32'(0));
            chk("diff_held_after_done", 32'(diff), 32'(md));
        end
    endtask

    vec_t         vecs[6];
    logic [W-1:0] gd;
    logic         gb, go;
    bit           saw_done;

    initial begin
        vecs[0] = '{a: 8'h5A, b: 8'h3C, diff: 8'h1E, bout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, bout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, bout: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'h10, b: 8'h01, diff: 8'h0F, bout: 1'b0, ovf: 1'b0};
        vecs[4] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, bout: 1'b1, ovf: 1'b0};
        vecs[5] = '{a: 8'h7F, b: 8'hFF, diff: 8'h80, bout: 1'b1, ovf: 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_diff", 32'(diff), 32'(0));
        chk("rst_borrow", 32'(borrow_out), 32'(0));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'(0));
`endif
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("idle_no_start", 32'(busy), 32'(0));

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, 1'b0, 1'b0, 1'b0, gd, gb, go);
            chk($sformatf("tbl%0d_diff", i), 32'(gd), 32'(vecs[i].diff));
            chk($sformatf("tbl%0d_borrow", i), 32'(gb), 32'(vecs[i].bout));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            chk($sformatf("tbl%0d_ovf", i), 32'(go), 32'(vecs[i].ovf));
`endif
        end

        // start held through RUN while operands change; captured operands must win.
        do_op(8'h5A, 8'h3C, 1'b1, 1'b1, 1'b0, gd, gb, go);
        chk("hold_diff", 32'(gd), 32'(8'h1E));

        // Reset in RUN cycle 4 aborts without a done pulse.
        a_i = 8'h5A; b_i = 8'h3C; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("pre_abort_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_diff", 32'(diff), 32'(0));
        chk("abort_borrow", 32'(borrow_out), 32'(0));
        saw_done = 1'b0;
        repeat (2 * W) begin
            @(posedge clk); @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'(0));
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, gd, gb, go);
        chk("post_abort_diff", 32'(gd), 32'(8'h1E));

        // Back-to-back: start in the DONE cycle.
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, gd, gb, go);
        do_op(8'h03, 8'h05, 1'b0, 1'b0, 1'b0, gd, gb, go);
        chk("b2b_diff", 32'(gd), 32'(8'hFE));
        chk("b2b_borrow", 32'(gb), 32'(1));

        for (int i = 0; i < 30; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0,
                  1'($urandom_range(0, 1)), gd, gb, go);
        end
        start = 1'b0;
        @(posedge clk); @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
